// File: rtl/vga_scan_if.sv
// Signal bundle between the raster generator, the pixel-draw block and the VGA pins.
// The master side is vga_scan; the slave side is the draw block plus the connector.
interface vga_scan_if;
  logic [11:0] pix_data;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic        vblank;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;

  modport master (
    input  pix_data,
    output x, y, frame_start, vblank, vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

  modport slave (
    output pix_data,
    input  x, y, frame_start, vblank, vga_r, vga_g, vga_b, vga_hs, vga_vs
  );
endinterface

// File: rtl/vga_scan.sv
// Raster timing generator and registered VGA output stage. Sync and blanking are
// delayed by PIX_LATENCY so they line up with the draw block's colour data.
module vga_scan #(
  parameter int H_VALID     = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VALID     = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_LATENCY = 1,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic       vga_clk,
  input  logic       rst_sys,
  vga_scan_if.master bus
);

  localparam int H_TOTAL = H_VALID + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VALID + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_VIS      = 10'(H_VALID);
  localparam logic [9:0] H_END      = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START   = 10'(H_VALID + H_FP);
  localparam logic [9:0] HS_STOP    = 10'(H_VALID + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS      = 10'(V_VALID);
  localparam logic [9:0] V_END      = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START   = 10'(V_VALID + V_FP);
  localparam logic [9:0] VS_STOP    = 10'(V_VALID + V_FP + V_SYNC);
  localparam logic       SYNC_IDLE  = ~SYNC_POL;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;

  assign h_end = (h_cnt == H_END);
  assign v_end = (v_cnt == V_END);

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk or negedge rst_sys) begin
    if (!rst_sys) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign bus.x = (h_cnt < H_VIS) ? h_cnt : '0;
  assign bus.y = (v_cnt < V_VIS) ? v_cnt[8:0] : '0;

  // Gating with rst_sys keeps the pulse low while held in reset at the origin.
  assign bus.frame_start = rst_sys && (h_cnt == '0) && (v_cnt == '0);
  assign bus.vblank      = (v_cnt >= V_VIS);

  logic de_raw;
  logic hs_raw;
  logic vs_raw;

  assign de_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw = ((h_cnt >= HS_START) && (h_cnt < HS_STOP)) ? SYNC_POL : SYNC_IDLE;
  assign vs_raw = ((v_cnt >= VS_START) && (v_cnt < VS_STOP)) ? SYNC_POL : SYNC_IDLE;

  logic [PIX_LATENCY-1:0] de_pipe;
  logic [PIX_LATENCY-1:0] hs_pipe;
  logic [PIX_LATENCY-1:0] vs_pipe;

  // NOTE: the delay pipes are reset, not left to flush, so no stale de/sync from
  // before a mid-frame reset can reach the pins after release.
  always_ff @(posedge vga_clk or negedge rst_sys) begin
    if (!rst_sys) begin
      de_pipe <= '0;
      hs_pipe <= {PIX_LATENCY{SYNC_IDLE}};
      vs_pipe <= {PIX_LATENCY{SYNC_IDLE}};
    end else begin
      de_pipe[0] <= de_raw;
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      for (int i = 1; i < PIX_LATENCY; i++) begin
        de_pipe[i] <= de_pipe[i-1];
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;

  always_ff @(posedge vga_clk or negedge rst_sys) begin
    if (!rst_sys) begin
      rgb_q <= '0;
      hs_q  <= SYNC_IDLE;
      vs_q  <= SYNC_IDLE;
    end else begin
      rgb_q <= de_pipe[PIX_LATENCY-1] ? bus.pix_data : '0;
      hs_q  <= hs_pipe[PIX_LATENCY-1];
      vs_q  <= vs_pipe[PIX_LATENCY-1];
    end
  end

  assign bus.vga_r  = rgb_q[11:8];
  assign bus.vga_g  = rgb_q[7:4];
  assign bus.vga_b  = rgb_q[3:0];
  assign bus.vga_hs = hs_q;
  assign bus.vga_vs = vs_q;

endmodule

// File: tb/tb_vga_scan.sv
// Randomized bench for vga_scan on a shrunken raster, compared cycle by cycle
// against a position-arithmetic model of the display timing.
module tb_vga_scan;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int LAT = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic vga_clk = 1'b0;
  logic rst_sys = 1'b0;

  vga_scan_if bus();

  vga_scan #(
    .H_VALID(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VALID(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_LATENCY(LAT), .SYNC_POL(1'b0)
  ) dut (
    .vga_clk(vga_clk),
    .rst_sys(rst_sys),
    .bus(bus)
  );

  always #5 vga_clk = ~vga_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          k;
  int          mode;
  logic [11:0] d_cur;
  logic [11:0] d_prev;
  int          hs_run, vs_run, white, last_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, mode %0d)", tag, got, exp, k, mode);
    end
  endtask

  function automatic int hpos(int p);
    return (p % FT) % HT;
  endfunction

  function automatic int vpos(int p);
    return (p % FT) / HT;
  endfunction

  function automatic bit active(int p);
    return (hpos(p) < HV) && (vpos(p) < VV);
  endfunction

  // Draw-block stand-in: data driven in cycle c belongs to the position shown at c-LAT.
  function automatic logic [11:0] draw_val(int c);
    int p;
    p = c - LAT;
    case (mode)
      0:       return (p >= 0 && hpos(p) < HV) ? 12'(hpos(p)) : 12'h000;
      1:       return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},  32'(bus.x), 0);
    check({tag, "_y"},  32'(bus.y), 0);
    check({tag, "_fs"}, 32'(bus.frame_start), 0);
    check({tag, "_vb"}, 32'(bus.vblank), 0);
    check({tag, "_hs"}, 32'(bus.vga_hs), 1);
    check({tag, "_vs"}, 32'(bus.vga_vs), 1);
    check({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
  endtask

  task automatic restart_model();
    k       = 0;
    d_prev  = '0;
    hs_run  = 0;
    vs_run  = 0;
    white   = 0;
    last_fs = -1;
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next rising edge.
  task automatic run_cycle();
    int          p;
    logic        exp_hs, exp_vs;
    logic [11:0] exp_rgb, rgb;
    d_cur        = draw_val(k);
    bus.pix_data = d_cur;
    @(negedge vga_clk);
    check("x",  32'(bus.x), (hpos(k) < HV) ? hpos(k) : 0);
    check("y",  32'(bus.y), (vpos(k) < VV) ? vpos(k) : 0);
    check("frame_start", 32'(bus.frame_start), (k % FT) == 0);
    check("vblank", 32'(bus.vblank), vpos(k) >= VV);
    p = k - LAT - 1;
    if (p < 0) begin
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = '0;
    end else begin
      exp_hs  = !(hpos(p) >= HV + HF && hpos(p) < HV + HF + HS);
      exp_vs  = !(vpos(p) >= VV + VF && vpos(p) < VV + VF + VS);
      exp_rgb = active(p) ? d_prev : 12'h000;
    end
    rgb = {bus.vga_r, bus.vga_g, bus.vga_b};
    check("vga_hs", 32'(bus.vga_hs), 32'(exp_hs));
    check("vga_vs", 32'(bus.vga_vs), 32'(exp_vs));
    check("rgb", 32'(rgb), 32'(exp_rgb));
    if (bus.vga_hs === 1'b0) hs_run++;
    else if (hs_run != 0) begin
      check("hs_width", hs_run, HS);
      hs_run = 0;
    end
    if (bus.vga_vs === 1'b0) vs_run++;
    else if (vs_run != 0) begin
      check("vs_width", vs_run, VS * HT);
      vs_run = 0;
    end
    if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", k - last_fs, FT);
      last_fs = k;
    end
    if (rgb === 12'hFFF) white++;
    @(posedge vga_clk);
    #1;
    d_prev = d_cur;
    k++;
  endtask

  initial begin
    int target;
    bus.pix_data = '0;
    mode = 0;
    restart_model();

    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check_reset_outputs("por");

    @(posedge vga_clk);
    #1;
    rst_sys = 1'b1;
    restart_model();

    mode = 0;
    repeat (2 * FT) run_cycle();

    mode  = 1;
    white = 0;
    repeat (2 * FT) run_cycle();
    check("white_count", white, 2 * HV * VV);

    mode   = 2;
    target = $urandom_range(VV - 2, 1) * HT + $urandom_range(HV - 2, 1);
    repeat (FT + target) run_cycle();

    // Mid-frame reset: outputs must drop to reset values without waiting for a clock.
    #1;
    rst_sys = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (3) @(posedge vga_clk);
    #1;
    check_reset_outputs("held");
    rst_sys = 1'b1;
    restart_model();

    mode = 1;
    repeat (2 * FT) run_cycle();
    check("white_after_rst", white, 2 * HV * VV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
Name: vga_scan

Overview:
- Raster timing generator and pixel output stage for the maze display.
- Produces the x/y scan coordinates consumed by the pixel-draw block.
- Takes back that block's registered 12-bit pix_data and drives the VGA pins (4-bit R/G/B, hsync, vsync).
- Delays sync and blanking to match the draw latency, so colour and sync arrive at the connector aligned.

Parameters:
- H_VALID, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VALID, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIX_LATENCY, 1, cycles from x/y presented to matching pix_data valid (1..4)
- SYNC_POL, 0, active level of hs/vs (0 = active-low)

Ports:
- vga_clk  input  1  pixel clock, 25.175 MHz nominal
- rst_sys  input  1  asynchronous, active-low reset
- pix_data  input  12  {R[11:8],G[7:4],B[3:0]} from draw, valid PIX_LATENCY cycles after x/y
- x  output  10  scan column for draw
- y  output  9  scan row for draw
- frame_start  output  1  one-cycle pulse at counter origin (h=0, v=0)
- vblank  output  1  high while v counter >= V_VALID (undelayed)
- vga_r  output  4  red to DAC
- vga_g  output  4  green
- vga_b  output  4  blue
- vga_hs  output  1  horizontal sync
- vga_vs  output  1  vertical sync

Behaviour:
- H_TOTAL = H_VALID+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VALID+V_FP+V_SYNC+V_BP (525).
- h_cnt is 10 bits, 0..H_TOTAL-1. It wraps to 0 at H_TOTAL-1; v_cnt increments on that wrap.
- v_cnt is 10 bits internally, 0..V_TOTAL-1. It wraps to 0 when h_cnt and v_cnt are both at terminal.
- Async reset (rst_sys low):
  - h_cnt = v_cnt = 0; x = y = 0.
  - frame_start = 0; vblank = 0.
  - vga_r/g/b = 0; vga_hs = vga_vs = ~SYNC_POL.
  - Delay pipes flushed to de = 0, hs/vs inactive.
- First clock after release: counters advance from 0, and frame_start pulses on the cycle where h_cnt = 0 and v_cnt = 0.
- x and y are combinational from the counters:
  - x = h_cnt when h_cnt < H_VALID, else 0.
  - y = v_cnt[8:0] when v_cnt < V_VALID, else 0.
  - Blanking-time values are don't-care to draw but must hold these defined values.
- Raw control signals per counter position:
  - de_raw = (h_cnt < H_VALID) && (v_cnt < V_VALID).
  - hs_raw = SYNC_POL when H_VALID+H_FP <= h_cnt < H_VALID+H_FP+H_SYNC, i.e. 656..751 by default; else ~SYNC_POL.
  - vs_raw = SYNC_POL when V_VALID+V_FP <= v_cnt < V_VALID+V_FP+V_SYNC, i.e. 490..491 by default. It is line-granular and changes with v_cnt at h_cnt = 0.
- Delay pipe: de_raw, hs_raw and vs_raw each pass through a PIX_LATENCY-deep shift register.
- Output register:
  - vga_hs/vga_vs take the delayed hs/vs.
  - vga_r/g/b take pix_data[11:8]/[7:4]/[3:0] when delayed de = 1, else 0.
- Net alignment: x/y presented at cycle t appear as a pixel on vga_* at cycle t+PIX_LATENCY+1, together with that position's sync levels. No colour is ever driven while delayed de = 0.
- frame_start and vblank are NOT delayed. They are for game-state updates, which must complete in blanking.
- Reset asserted mid-frame: all outputs go to reset values immediately (async). After release, timing restarts at origin; no partial pipe content emerges.
- No handshake: pix_data is sampled unconditionally every cycle.

Test Plan:
- Reset then release -> vga_hs = vga_vs = 1 and rgb = 0 during reset; frame_start high exactly on first cycle at h = v = 0, then every 420000 cycles.
- Count hs -> vga_hs low for 96 consecutive cycles per 800-cycle line, falling edge 658 cycles (656 + PIX_LATENCY + 1) after the line's h_cnt = 0.
- Count vs -> vga_vs low for exactly 2 lines (1600 cycles) per 525-line frame, starting at line 490 (+2 cycle pipe offset); vblank high for lines 480..524.
- Drive pix_data = {2'b0, x} (low 12 bits) and a checker model -> at every active pixel, rgb equals value for x/y from 2 cycles earlier; first pixel of line 0 shows x = 0, last shows x = 639; y wraps 479 -> 0 via blank.
- Drive pix_data = 12'hFFF constant -> rgb = 0 for all cycles where shifted h >= 640 or v >= 480; 640*480 = 307200 white pixels per frame.
- Assert rst_sys at h = 300, v = 200 for 3 cycles -> outputs at reset values asynchronously (same cycle); after release h/v restart at 0 and no stale white pixel appears.
